x_stream_feeder: RTL and testbench
==================================

X_STREAM_FEEDER -- requirements
Module: x_stream_feeder

Interface
REQ-001 Parameter DEPTH, default 4, byte FIFO depth; legal values 2, 4, 8.
REQ-002 clk  input  1  Single clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  Synchronous reset, active-high.
REQ-004 in_data  input  8  Byte to be serialized onto x.
REQ-005 in_valid  input  1  in_data is offered this cycle.
REQ-006 in_ready  output  1  FIFO can accept a byte this cycle.
REQ-007 step  input  1  The downstream next-state logic consumes the current x bit at this edge.
REQ-008 x  output  1  Current serial bit; this is the x input of the downstream next-state logic.
REQ-009 x_valid  output  1  x holds a real bit.
REQ-010 x_first  output  1  x is the MSB (bit 7) of a byte.
REQ-011 count  output  4  Number of bytes in the FIFO, excluding the byte in the shifter.
REQ-012 overflow  output  1  Sticky flag: a byte was offered while the FIFO was full.

Function
REQ-013 Push: a byte is accepted when in_valid and in_ready are both 1 at a rising edge, and is written at the FIFO tail.
REQ-014 in_ready equals (count != DEPTH) and reset is 0; it is derived from registered count only and is independent of step in the same cycle.
REQ-015 Shifter states:
- IDLE: x_valid=0.
- SHIFT: x_valid=1; 3-bit bit_idx counts 7 down to 0.
REQ-016 Entering SHIFT: in IDLE with count>0 at an edge, the FIFO head is popped into the shifter and bit_idx=7. x_valid and x_first are 1 from that edge on.
REQ-017 Byte latency: a push accepted into an empty FIFO with the shifter in IDLE at edge t gives x_valid=1 after edge t+1.
REQ-018 x equals shifter bit bit_idx, MSB first; x_first equals (bit_idx==7) and x_valid.
REQ-019 step in SHIFT with bit_idx>0: bit_idx decrements by 1.
REQ-020 step in SHIFT with bit_idx==0:
- count>0: the next byte is popped in the same edge and bit_idx=7; x_valid stays 1 (no bubble).
- count==0: the block returns to IDLE.
REQ-021 step while x_valid=0 is ignored.
REQ-022 Simultaneous push and pop at the same edge: count is unchanged, and the FIFO order is preserved.
REQ-023 A push into an empty FIFO at the same edge as a pop attempt does not bypass: the pop sees count==0 and the block takes the IDLE/return-to-IDLE path.
REQ-024 in_valid while in_ready=0 drops the byte: the FIFO is unchanged and overflow is set to 1 until reset.
REQ-025 FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; count saturates at neither end because push and pop are gated.

Reset
REQ-026 While reset=1 at an edge, the following are cleared: the FIFO pointers, count=0, the shifter returns to IDLE, bit_idx=7, x=0, and overflow=0.
REQ-027 in_ready=0 during reset, x_valid=0, and x_first=0; in_valid and step are ignored.
REQ-028 Reset asserted mid-byte discards the partial byte and all queued bytes; no bit is emitted after reset deasserts until a new push.
REQ-029 In the first cycle after reset deasserts, in_ready=1 and count=0.

Verification
REQ-030 Single byte: push 0xA5 at edge t into an empty block, then step every cycle.
- Response: x_valid rises after t+1 with x_first=1; x sequence is 1,0,1,0,0,1,0,1; x_valid falls after the 8th step.
REQ-031 Back-to-back bytes: push 0xF0 and 0x0F, then step continuously.
- Response: 16 contiguous x_valid cycles reading 1111000000001111; x_first=1 at bits 0 and 8.
REQ-032 Fill and overflow with DEPTH=4 and step=0: push 6 bytes.
- Response: the first byte is in the shifter and 4 bytes are in the FIFO (count=4, in_ready=0).
- The 6th byte is dropped and overflow=1.
- Drain yields the first 5 bytes in order.
REQ-033 Simultaneous push/pop with count=2: the last-bit step coincides with an accepted push.
- Response: count stays 2, the new byte emerges last, and the data order is intact.
REQ-034 Step gaps: step is pulsed every 3rd cycle on 0x81.
- Response: each bit holds until its step; the sequence is 1,0,0,0,0,0,0,1.
- step while IDLE has no effect.
REQ-035 Reset mid-byte: assert reset after 3 steps of 0xC3 with 2 bytes queued.
- Response: the next cycle shows count=0, x_valid=0, overflow=0.
- A fresh push of 0x55 emits 0,1,0,1,0,1,0,1.

Source files
------------

// File: rtl/x_stream_feeder.sv
// Byte FIFO feeding an MSB-first serial bit stream.
// Each x bit is held until the downstream logic consumes it with step.
module x_stream_feeder #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       step,
  output logic       x,
  output logic       x_valid,
  output logic       x_first,
  output logic [3:0] count,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] FULL = 4'(DEPTH);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]    count_q, count_d;
  logic [0:0]    state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  logic          ovf_q;
  logic          push, pop;

  assign in_ready = !reset && (count_q != FULL);
  assign push     = in_valid && in_ready;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign x        = sh_q[bit_q];
  assign x_valid  = !reset && (state_q == S_SHIFT);
  assign x_first  = x_valid && (bit_q == 3'd7);

  // Pop reads the pre-edge count, so a same-edge push never bypasses.
  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    if (state_q == S_IDLE) begin
      if (count_q != 4'd0) pop = 1'b1;
    end else if (step) begin
      if (bit_q != 3'd0)
        bit_d = bit_q - 3'd1;
      else if (count_q != 4'd0)
        pop = 1'b1;
      else
        state_d = S_IDLE;
    end
    if (pop) begin
      sh_d    = mem_q[rd_ptr_q];
      bit_d   = 3'd7;
      state_d = S_SHIFT;
    end
    count_d = count_q + {3'd0, push} - {3'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      state_q  <= S_IDLE;
      sh_q     <= 8'd0;
      bit_q    <= 3'd7;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      if (in_valid && !in_ready) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_x_stream_feeder.sv
// Bench for x_stream_feeder: directed scenarios and random traffic
// compared cycle by cycle against a queue-based reference.
module tb_x_stream_feeder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       step = 1'b0;
  logic       x, x_valid, x_first;
  logic [3:0] count;
  logic       overflow;

  int total = 0;
  int bad = 0;

  x_stream_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .step(step),
    .x(x), .x_valid(x_valid), .x_first(x_first),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // reference: queued bytes, current byte, bits already consumed
  byte unsigned q[$];
  logic [7:0]   cur = 8'd0;
  bit           act = 1'b0;
  int           nbit = 0;
  bit           ovf = 1'b0;
  bit           in_rst = 1'b1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(bit r, bit v, logic [7:0] d, bit s);
    int n;
    bit pushed, popped;
    if (r) begin
      q.delete();
      act = 0; nbit = 0; ovf = 0; cur = 8'd0;
      return;
    end
    n = q.size();
    pushed = v && (n < DEPTH);
    if (v && n == DEPTH) ovf = 1;
    popped = 0;
    if (!act) begin
      if (n > 0) popped = 1;
    end else if (s) begin
      if (nbit < 7) nbit++;
      else if (n > 0) popped = 1;
      else act = 0;
    end
    if (popped) begin
      cur = q.pop_front();
      act = 1; nbit = 0;
    end
    if (pushed) q.push_back(d);
  endtask

  task automatic compare();
    chk("in_ready", in_ready, !in_rst && q.size() != DEPTH);
    chk("count", count, q.size());
    chk("x_valid", x_valid, act && !in_rst);
    chk("x_first", x_first, act && !in_rst && nbit == 0);
    chk("overflow", overflow, ovf);
    if (act && !in_rst) chk("x", x, cur[7-nbit]);
  endtask

  task automatic tick(bit r, bit v, logic [7:0] d, bit s);
    reset = r; in_valid = v; in_data = d; step = s;
    @(posedge clk);
    model_step(r, v, d, s);
    @(negedge clk);
    in_rst = r;
    compare();
  endtask

  task automatic do_reset();
    tick(1, 0, 8'd0, 0);
    tick(1, 1, 8'hFF, 1);
    tick(0, 0, 8'd0, 0);
  endtask

  task automatic idle_steps(int n, int gap);
    for (int i = 0; i < n; i++) tick(0, 0, 8'd0, (i % gap) == gap - 1);
  endtask

  int pv, ps, pr;

  initial begin
    @(negedge clk);
    do_reset();
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_count", count, 0);

    // single byte
    tick(0, 1, 8'hA5, 0);
    chk("latency_pre", x_valid, 0);
    tick(0, 0, 8'd0, 0);
    chk("latency_valid", x_valid, 1);
    idle_steps(10, 1);
    chk("a5_done", x_valid, 0);

    // back-to-back
    tick(0, 1, 8'hF0, 0);
    tick(0, 1, 8'h0F, 0);
    idle_steps(20, 1);

    // fill and overflow
    for (int i = 0; i < 6; i++) tick(0, 1, 8'(8'h10 + i), 0);
    chk("fill_count", count, 4);
    chk("fill_ready", in_ready, 0);
    chk("fill_ovf", overflow, 1);
    idle_steps(48, 1);

    // same-edge push and pop with count=2
    tick(0, 1, 8'h3C, 0);
    tick(0, 1, 8'h11, 0);
    tick(0, 1, 8'h22, 0);
    idle_steps(7, 1);
    tick(0, 1, 8'h33, 1);
    chk("pushpop_count", count, 2);
    idle_steps(30, 1);

    // step gaps, and step while idle
    tick(0, 1, 8'h81, 0);
    idle_steps(30, 3);
    idle_steps(4, 1);

    // reset mid-byte
    do_reset();
    tick(0, 1, 8'hC3, 0);
    tick(0, 1, 8'h01, 0);
    tick(0, 1, 8'h02, 0);
    idle_steps(3, 1);
    tick(1, 1, 8'h99, 0);
    tick(0, 0, 8'd0, 1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", x_valid, 0);
    idle_steps(3, 1);
    tick(0, 1, 8'h55, 0);
    idle_steps(12, 1);

    // random traffic in phases of differing load
    for (int ph = 0; ph < 20; ph++) begin
      pv = $urandom_range(10, 95);
      ps = $urandom_range(10, 100);
      pr = (ph % 5 == 4) ? 2 : 0;
      for (int i = 0; i < 200; i++)
        tick($urandom_range(0, 199) < pr,
             $urandom_range(0, 99) < pv,
             8'($urandom),
             $urandom_range(0, 99) < ps);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
